// File: rtl/fetch_stage_pkg.sv
// Shared widths, constants and helpers for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  // One buffered fetch result handed to IF/ID.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Fetches are word-aligned; the low two bits of any target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_stage_sync_fifo.sv
// Small synchronous FIFO with combinational head, occupancy count and flush.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_rd [DEPTH];

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  // Flush wins over both push and pop in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_q, entry_d;

      always_comb begin
        entry_d = entry_q;
        if (do_push && (wr_ptr_q == AW'(gi))) entry_d = push_data;
      end

      always_ff @(posedge clk) begin
        entry_q <= entry_d;
      end

      assign mem_rd[gi] = entry_q;
    end
  endgenerate

  assign head_data = mem_rd[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches and
// buffers in-order responses for IF/ID, discarding wrong-path data after redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [ILEN-1:0]  imem_rsp_data,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             if_valid,
  output logic [XLEN-1:0]  if_pc_out,
  output logic [ILEN-1:0]  if_instr_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   discard_cnt_q, discard_cnt_d;

  logic [CW-1:0]   pcq_count, buf_count;
  logic            pcq_empty, pcq_full, buf_empty, buf_full;
  logic [XLEN-1:0] pcq_head;
  fetch_entry_t    buf_head, buf_push_data;
  logic            pcq_push, pcq_pop, buf_push, buf_pop, buf_flush;
  logic            req_fire, rsp_fire, credit_ok;
  logic [CW:0]     in_use;

  // Outstanding requests are exactly the PCs waiting in the PC queue,
  // including wrong-path ones that will be dropped on return.
  assign in_use         = {1'b0, buf_count} + {1'b0, pcq_count};
  assign credit_ok      = (in_use < (CW+1)'(DEPTH));
  assign imem_req_valid = reset_n && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is ignored so state stays consistent.
  assign rsp_fire       = imem_rsp_valid && !pcq_empty;

  always_comb begin
    pc_d          = pc_q;
    discard_cnt_d = discard_cnt_q;
    pcq_push      = 1'b0;
    pcq_pop       = rsp_fire;
    buf_push      = 1'b0;
    buf_pop       = 1'b0;
    buf_flush     = 1'b0;
    buf_push_data = '{pc: pcq_head, instr: imem_rsp_data};

    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      buf_flush     = 1'b1;
      pc_d          = align_pc(redirect_pc);
      discard_cnt_d = pcq_count - CW'(rsp_fire);
    end else begin
      if (req_fire) begin
        pcq_push = 1'b1;
        pc_d     = pc_q + PC_INC;
      end
      if (rsp_fire) begin
        if (discard_cnt_q != '0) discard_cnt_d = discard_cnt_q - CW'(1);
        else                     buf_push      = 1'b1;
      end
      buf_pop = !buf_empty && !stall;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      discard_cnt_q <= '0;
    end else begin
      pc_q          <= pc_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (1'b0),
    .push      (pcq_push),
    .push_data (pc_q),
    .pop       (pcq_pop),
    .head_data (pcq_head),
    .count     (pcq_count),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (buf_flush),
    .push      (buf_push),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .head_data (buf_head),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  assign if_valid     = !buf_empty;
  assign if_pc_out    = buf_empty ? '0 : buf_head.pc;
  assign if_instr_out = buf_empty ? '0 : buf_head.instr;

  a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rsp_valid |-> !pcq_empty);
  a_buf_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    buf_push |-> !buf_full);
  a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    pcq_push |-> !pcq_full);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised and directed checking of fetch_stage against a queue-based model.
module tb_fetch_stage;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_pc_out;
  logic [31:0] if_instr_out;

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc_out      (if_pc_out),
    .if_instr_out   (if_instr_out)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct packed { logic [31:0] pc; logic dead; } fly_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] due; } mreq_t;

  ent_t        m_buf[$];
  fly_t        m_fly[$];
  mreq_t       memq[$];
  logic [31:0] m_pc = '0;
  int          cyc = 0;
  int          lat = 1;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    memq.delete(); m_buf.delete(); m_fly.delete();
    m_pc = 32'h0000_0000;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_if_valid", if_valid, 1'b0);
      chk("rst_if_pc", if_pc_out, 32'h0);
      chk("rst_if_instr", if_instr_out, 32'h0);
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model and the memory by what the coming edge does.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic  exp_rv;
    logic  rsp;
    logic  got;
    fly_t  f;
    @(negedge clk);
    cyc++;
    stall = st; redirect_valid = rd; redirect_pc = rpc; imem_req_ready = rdy;
    rsp = 1'b0;
    imem_rsp_data = '0;
    if (memq.size() > 0 && int'(memq[0].due) <= cyc) begin
      rsp = 1'b1;
      imem_rsp_data = memq[0].addr ^ KEY;
      void'(memq.pop_front());
    end
    imem_rsp_valid = rsp;
    #1;
    exp_rv = !rd && ((m_buf.size() + m_fly.size()) < DEPTH);
    chk("if_valid", if_valid, m_buf.size() != 0);
    chk("if_pc", if_pc_out, (m_buf.size() != 0) ? m_buf[0].pc : 32'h0);
    chk("if_instr", if_instr_out, (m_buf.size() != 0) ? m_buf[0].instr : 32'h0);
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    if (if_valid && !st && !rd)
      $display("xfer cycle=%0d pc=%h instr=%h", cyc, if_pc_out, if_instr_out);
    if (imem_req_valid && imem_req_ready)
      memq.push_back('{addr: imem_req_addr, due: 32'(cyc + lat)});

    got = 1'b0;
    f = '0;
    if (rsp && m_fly.size() > 0) begin
      f = m_fly[0];
      void'(m_fly.pop_front());
      got = !f.dead && !rd;
    end
    if (rd) begin
      m_buf.delete();
      foreach (m_fly[i]) begin
        fly_t t;
        t = m_fly[i];
        t.dead = 1'b1;
        m_fly[i] = t;
      end
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (m_buf.size() > 0 && !st) void'(m_buf.pop_front());
      if (got) m_buf.push_back('{pc: f.pc, instr: f.pc ^ KEY});
      if (exp_rv && rdy) begin
        m_fly.push_back('{pc: m_pc, dead: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;

    // Reset, then 1-cycle streaming: if_pc 0,4,8,... from cycle 2 with no gaps.
    do_reset();
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (k == 0) begin
        chk("first_req_valid", imem_req_valid, 1'b1);
        chk("first_req_addr", imem_req_addr, 32'h0000_0000);
      end
      if (k >= 2) begin
        chk("stream_valid", if_valid, 1'b1);
        chk("stream_pc", if_pc_out, 32'(4 * (k - 2)));
        chk("stream_instr", if_instr_out, 32'(4 * (k - 2)) ^ KEY);
      end
    end

    // Backpressure: issue stops at 4 in use, then delivery resumes in order.
    for (int k = 10; k < 15; k++) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("bp_req_valid", imem_req_valid, 1'b0);
    chk("bp_req_addr", imem_req_addr, 32'h30);
    chk("bp_head_pc", if_pc_out, 32'h20);
    for (int k = 15; k < 20; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk("bp_resume_valid", if_valid, 1'b1);
      chk("bp_resume_pc", if_pc_out, 32'h20 + 32'(4 * (k - 15)));
    end

    // Memory not ready: request held at the same address, then accepted.
    for (int k = 20; k < 24; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk("nr_req_valid", imem_req_valid, 1'b1);
      chk("nr_req_addr", imem_req_addr, 32'h40);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("nr_resume_addr", imem_req_addr, 32'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("nr_next_addr", imem_req_addr, 32'h44);

    // Redirect in the same cycle as the response for 0x8.
    do_reset();
    lat = 1;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    chk("sc_rsp_seen", imem_rsp_valid, 1'b1);
    chk("sc_no_req", imem_req_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("sc_target_req", imem_req_addr, 32'h40);
    chk("sc_gap1", if_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("sc_gap2", if_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("sc_target_valid", if_valid, 1'b1);
    chk("sc_target_pc", if_pc_out, 32'h40);

    // Redirect with three requests in flight on a 3-cycle memory.
    lat = 3;
    waited = 0;
    while (m_fly.size() != 3 && waited < 30) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      waited++;
    end
    chk("fly3_reached", 32'(m_fly.size()), 32'd3);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("rf_req_valid", imem_req_valid, 1'b1);
    chk("rf_req_addr", imem_req_addr, 32'h100);
    waited = 0;
    while (!if_valid && waited < 15) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      waited++;
    end
    chk("rf_first_pc", if_pc_out, 32'h100);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    waited = 0;
    while (!if_valid && waited < 15) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      waited++;
    end
    chk("rf_second_pc", if_pc_out, 32'h104);

    // Random traffic with a reset part way through.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      lat = int'($urandom_range(1, 3));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom,
           $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
